// File: rtl/alu_issue_stage.sv
// ID->EX issue register: decodes RV32I instr + operands into ALU a/b/op, holds one entry.
// Latency 1 cycle, full throughput with out_ready=1.
// Backpressure: in_ready = ~out_valid | out_ready; on stall every output holds; flush wins.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_control,
    output logic [4:0]      rd,
    output logic            rd_we,
    output logic            is_branch,
    output logic [2:0]      br_funct3,
    output logic [XLEN-1:0] store_data,
    output logic            illegal
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      ctl;
        logic [4:0]      rd;
        logic            rd_we;
        logic            is_branch;
        logic [2:0]      br_f3;
        logic [XLEN-1:0] store_data;
        logic            illegal;
    } issue_t;

    function automatic logic [3:0] funct3_op(input logic [2:0] f3);
        case (f3)
            3'b000:  funct3_op = ALU_ADD;
            3'b001:  funct3_op = ALU_SLL;
            3'b010:  funct3_op = ALU_SLT;
            3'b011:  funct3_op = ALU_SLTU;
            3'b100:  funct3_op = ALU_XOR;
            3'b101:  funct3_op = ALU_SRL;
            3'b110:  funct3_op = ALU_OR;
            default: funct3_op = ALU_AND;
        endcase
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;
    logic            bad_enc;
    issue_t          dec;
    issue_t          held;
    state_t          state_q;
    state_t          state_d;
    logic            load;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = {instr[31:12], 12'b0};
    assign shamt  = {27'b0, instr[24:20]};

    always_comb begin
        dec            = '0;
        bad_enc        = 1'b0;
        dec.rd         = instr[11:7];
        dec.store_data = rs2_data;
        dec.ctl        = ALU_ADD;
        case (opcode)
            OPC_OP: begin
                dec.a     = rs1_data;
                dec.b     = rs2_data;
                dec.rd_we = 1'b1;
                if (funct7 == F7_ZERO)
                    dec.ctl = funct3_op(funct3);
                else if (funct7 == F7_ALT && funct3 == 3'b000)
                    dec.ctl = ALU_SUB;
                else if (funct7 == F7_ALT && funct3 == 3'b101)
                    dec.ctl = ALU_SRA;
                else
                    bad_enc = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.a     = rs1_data;
                dec.b     = imm_i;
                dec.rd_we = 1'b1;
                dec.ctl   = funct3_op(funct3);
                // Shifts carry shamt in imm[4:0]; upper imm bits are funct7.
                if (funct3 == 3'b001) begin
                    dec.b = shamt;
                    if (funct7 != F7_ZERO)
                        bad_enc = 1'b1;
                end else if (funct3 == 3'b101) begin
                    dec.b = shamt;
                    if (funct7 == F7_ALT)
                        dec.ctl = ALU_SRA;
                    else if (funct7 != F7_ZERO)
                        bad_enc = 1'b1;
                end
            end
            OPC_LUI: begin
                dec.b     = imm_u;
                dec.rd_we = 1'b1;
            end
            OPC_AUIPC: begin
                dec.a     = pc;
                dec.b     = imm_u;
                dec.rd_we = 1'b1;
            end
            OPC_LOAD: begin
                dec.a     = rs1_data;
                dec.b     = imm_i;
                dec.rd_we = 1'b1;
            end
            OPC_STORE: begin
                dec.a = rs1_data;
                dec.b = imm_s;
            end
            OPC_BRANCH: begin
                dec.a         = rs1_data;
                dec.b         = rs2_data;
                dec.is_branch = 1'b1;
                dec.br_f3     = funct3;
                case (funct3)
                    3'b000, 3'b001: dec.ctl = ALU_SUB;
                    3'b100, 3'b101: dec.ctl = ALU_SLT;
                    3'b110, 3'b111: dec.ctl = ALU_SLTU;
                    default:        bad_enc = 1'b1;
                endcase
            end
            OPC_JAL, OPC_JALR: begin
                dec.a     = pc;
                dec.b     = 32'd4;
                dec.rd_we = 1'b1;
            end
            default: bad_enc = 1'b1;
        endcase
        if (bad_enc) begin
            dec.a         = '0;
            dec.b         = '0;
            dec.ctl       = ALU_ADD;
            dec.rd_we     = 1'b0;
            dec.is_branch = 1'b0;
            dec.br_f3     = 3'b0;
            dec.illegal   = 1'b1;
        end
        if (dec.rd == 5'd0)
            dec.rd_we = 1'b0;
    end

    assign in_ready  = (state_q == EMPTY) | out_ready;
    assign out_valid = (state_q == FULL);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_valid && !flush) begin
                    state_d = FULL;
                    load    = 1'b1;
                end
            end
            FULL: begin
                if (flush)
                    state_d = EMPTY;
                else if (out_ready) begin
                    if (in_valid)
                        load = 1'b1;
                    else
                        state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    // Flush only clears the side-effect bits; operand payload may stay stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held <= '0;
        end else if (flush) begin
            held.rd_we     <= 1'b0;
            held.is_branch <= 1'b0;
            held.illegal   <= 1'b0;
        end else if (load) begin
            held <= dec;
        end
    end

    assign alu_a       = held.a;
    assign alu_b       = held.b;
    assign alu_control = held.ctl;
    assign rd          = held.rd;
    assign rd_we       = held.rd_we;
    assign is_branch   = held.is_branch;
    assign br_funct3   = held.br_f3;
    assign store_data  = held.store_data;
    assign illegal     = held.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: a reference decoder pushes expected entries on
// accept; a monitor pops and compares them on every consume.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_control;
    logic [4:0]  rd;
    logic        rd_we;
    logic        is_branch;
    logic [2:0]  br_funct3;
    logic [31:0] store_data;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctl;
        logic [4:0]  rd;
        logic        we;
        logic        br;
        logic [2:0]  f3;
        logic [31:0] sd;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];

    alu_issue_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .rd(rd),
        .rd_we(rd_we), .is_branch(is_branch), .br_funct3(br_funct3),
        .store_data(store_data), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] op_of_f3(input logic [2:0] f3);
        logic [3:0] r;
        case (f3)
            3'd0: r = 4'd0;  3'd1: r = 4'd7;  3'd2: r = 4'd5;  3'd3: r = 4'd6;
            3'd4: r = 4'd4;  3'd5: r = 4'd8;  3'd6: r = 4'd3;  default: r = 4'd2;
        endcase
        return r;
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pcv,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t        e;
        logic        bad;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] immi;
        op   = ins[6:0];
        f3   = ins[14:12];
        f7   = ins[31:25];
        immi = {{20{ins[31]}}, ins[31:20]};
        e    = '0;
        bad  = 1'b0;
        e.rd = ins[11:7];
        e.sd = r2;
        if (op == 7'h33) begin
            e.a = r1; e.b = r2; e.we = 1'b1;
            if (f7 == 7'h00)                  e.ctl = op_of_f3(f3);
            else if (f7 == 7'h20 && f3 == 3'd0) e.ctl = 4'd1;
            else if (f7 == 7'h20 && f3 == 3'd5) e.ctl = 4'd9;
            else                              bad = 1'b1;
        end else if (op == 7'h13) begin
            e.a = r1; e.we = 1'b1;
            if (f3 == 3'd1 || f3 == 3'd5) begin
                e.b = {27'b0, ins[24:20]};
                if (f7 == 7'h00)                  e.ctl = op_of_f3(f3);
                else if (f7 == 7'h20 && f3 == 3'd5) e.ctl = 4'd9;
                else                              bad = 1'b1;
            end else begin
                e.b = immi; e.ctl = op_of_f3(f3);
            end
        end else if (op == 7'h37 || op == 7'h17) begin
            e.a = (op == 7'h17) ? pcv : 32'd0;
            e.b = {ins[31:12], 12'h000}; e.we = 1'b1;
        end else if (op == 7'h03) begin
            e.a = r1 + 32'd0; e.b = immi; e.we = 1'b1;
        end else if (op == 7'h23) begin
            e.a = r1; e.b = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        end else if (op == 7'h63) begin
            e.a = r1; e.b = r2; e.br = 1'b1; e.f3 = f3;
            if (f3 == 3'd2 || f3 == 3'd3) bad = 1'b1;
            else if (f3[2] == 1'b0)       e.ctl = 4'd1;
            else if (f3[1] == 1'b0)       e.ctl = 4'd5;
            else                          e.ctl = 4'd6;
        end else if (op == 7'h6F || op == 7'h67) begin
            e.a = pcv; e.b = 32'd4; e.we = 1'b1;
        end else begin
            bad = 1'b1;
        end
        if (bad) begin
            e.a = '0; e.b = '0; e.ctl = '0; e.we = 1'b0; e.br = 1'b0; e.f3 = '0; e.ill = 1'b1;
        end
        if (e.rd == 5'd0) e.we = 1'b0;
        return e;
    endfunction

    task automatic compare_entry(input exp_t e);
        check("alu_a", alu_a, e.a);
        check("alu_b", alu_b, e.b);
        check("alu_control", {28'b0, alu_control}, {28'b0, e.ctl});
        check("rd", {27'b0, rd}, {27'b0, e.rd});
        check("rd_we", {31'b0, rd_we}, {31'b0, e.we});
        check("is_branch", {31'b0, is_branch}, {31'b0, e.br});
        check("br_funct3", {29'b0, br_funct3}, {29'b0, e.f3});
        if (e.ctl == 4'd0 && !e.ill && !e.we && !e.br)
            check("store_data", store_data, e.sd);
        check("illegal", {31'b0, illegal}, {31'b0, e.ill});
    endtask

    // Inputs change at posedge+1; accept is decided by in_ready at the following negedge.
    task automatic issue(input logic [31:0] ins, input logic [31:0] pcv,
                         input logic [31:0] r1, input logic [31:0] r2);
        bit accepted = 0;
        instr = ins; pc = pcv; rs1_data = r1; rs2_data = r2; in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(ins, pcv, r1, r2));
                accepted = 1;
                break;
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
        end
        if (!accepted) check("issue_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] ins;
        logic [6:0]  ops [10];
        ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h0B};

        rst = 1'b1; in_valid = 1'b0; instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
        flush = 1'b0; out_ready = 1'b0;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_illegal", {31'b0, illegal}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (!rst && out_valid) begin
                    if (flush) begin
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                    end else if (out_ready) begin
                        if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
                        else compare_entry(exp_q.pop_front());
                    end
                end
            end
        join_none

        // Directed decode cases, back to back
        out_ready = 1'b1;
        issue({7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33}, 32'h0, 32'd5, 32'd7);
        issue({7'h20, 5'd4, 5'd6, 3'd5, 5'd5, 7'h13}, 32'h4, 32'h8000_0000, 32'd0);
        issue({7'h20, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33}, 32'h8, 32'd9, 32'd4);
        issue({12'd1, 5'd0, 3'd0, 5'd0, 7'h13}, 32'hC, 32'd0, 32'd0);
        issue({7'h00, 5'd2, 5'd1, 3'd6, 5'd8, 7'h63}, 32'h100, 32'd1, 32'd2);
        issue({7'h00, 5'd2, 5'd1, 3'd2, 5'd8, 7'h63}, 32'h104, 32'd1, 32'd2);
        issue({7'h00, 5'd2, 5'd1, 3'd2, 5'd8, 7'h23}, 32'h108, 32'd100, 32'hDEAD_BEEF);
        issue({12'hFFC, 5'd1, 3'd2, 5'd4, 7'h03}, 32'h10C, 32'd100, 32'd0);
        issue({20'h00010, 5'd1, 7'h6F}, 32'h110, 32'd0, 32'd0);
        issue({20'hABCDE, 5'd9, 7'h17}, 32'h114, 32'd0, 32'd0);
        idle(3);

        // Stall: held entry must not move while a new instr waits
        out_ready = 1'b0;
        issue({7'h00, 5'd2, 5'd1, 3'd7, 5'd10, 7'h33}, 32'h200, 32'hF0F0, 32'h0FF0);
        instr = {7'h00, 5'd3, 5'd4, 3'd4, 5'd11, 7'h33};
        rs1_data = 32'h1234; rs2_data = 32'h4321; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", {31'b0, in_ready}, 32'd0);
            check("stall_out_valid", {31'b0, out_valid}, 32'd1);
            check("stall_hold_a", alu_a, 32'hF0F0);
            check("stall_hold_ctl", {28'b0, alu_control}, 32'd2);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        issue({7'h00, 5'd3, 5'd4, 3'd4, 5'd11, 7'h33}, 32'h204, 32'h1234, 32'h4321);
        check("release_out_valid", {31'b0, out_valid}, 32'd1);
        idle(3);

        // Flush while FULL with a same-cycle input
        out_ready = 1'b0;
        issue({12'd7, 5'd1, 3'd0, 5'd12, 7'h13}, 32'h300, 32'd1, 32'd0);
        instr = {7'h00, 5'd2, 5'd1, 3'd0, 5'd13, 7'h33}; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check("flush_rd_we", {31'b0, rd_we}, 32'd0);
        check("flush_illegal", {31'b0, illegal}, 32'd0);
        idle(2);
        check("flush_dropped", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b1;
        issue({20'h12345, 5'd7, 7'h37}, 32'h304, 32'd0, 32'd0);
        idle(3);

        // Async reset while FULL and stalled
        out_ready = 1'b0;
        issue({7'h00, 5'd2, 5'd1, 3'd0, 5'd14, 7'h23}, 32'h400, 32'd55, 32'd66);
        in_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check("arst_alu_a", alu_a, 32'd0);
        check("arst_alu_b", alu_b, 32'd0);
        check("arst_rd", {27'b0, rd}, 32'd0);
        check("arst_store_data", store_data, 32'd0);
        check("arst_ctl", {28'b0, alu_control}, 32'd0);
        exp_q.delete();
        in_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        out_ready = 1'b1;
        issue(32'h0000_007F, 32'h500, 32'd1, 32'd2);
        idle(2);

        // Randomised traffic with random backpressure
        for (int i = 0; i < 150; i++) begin
            r   = $urandom;
            ins = {r[31:7], ops[$urandom_range(0, 9)]};
            if (ins[6:0] == 7'h33 && r[0]) ins[31:25] = r[1] ? 7'h20 : 7'h00;
            if (ins[6:0] == 7'h13 && r[2]) ins[31:25] = r[3] ? 7'h20 : 7'h00;
            out_ready = 1'($urandom_range(0, 1));
            issue(ins, $urandom, $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) in_valid = 1'b0;
        end
        out_ready = 1'b1;
        idle(5);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
